ghost_scheduler: RTL and testbench

GHOST_SCHEDULER -- requirements
Module: ghost_scheduler

---
 rtl/ghost_scheduler_if.sv | 34 +++
 rtl/ghost_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ghost_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghost_scheduler_if.sv
// Ghost scheduler port bundle: round control, ghost handshake, map port and status flags.
// Latency: none (signal bundle only).
// Backpressure: ghosts throttle the scheduler through ghost_is_ready; there is no other stall path.
interface ghost_scheduler_if;
  logic        frame_tick;
  logic [3:0]  ghost_is_ready;
  logic [3:0]  ghost_hit;
  logic [19:0] ghost_map_x;
  logic [19:0] ghost_map_y;
  logic [3:0]  ghost_start;
  logic [4:0]  map_x;
  logic [4:0]  map_y;
  logic        map_readwrite;
  logic        round_busy;
  logic        round_done;
  logic        pacman_caught;
  logic [1:0]  caught_id;
  logic        overrun;
  logic        timeout_err;

  // Scheduler side
  modport master (
    input  frame_tick, ghost_is_ready, ghost_hit, ghost_map_x, ghost_map_y,
    output ghost_start, map_x, map_y, map_readwrite, round_busy, round_done,
           pacman_caught, caught_id, overrun, timeout_err
  );

  // Ghost / game-logic side
  modport slave (
    output frame_tick, ghost_is_ready, ghost_hit, ghost_map_x, ghost_map_y,
    input  ghost_start, map_x, map_y, map_readwrite, round_busy, round_done,
           pacman_caught, caught_id, overrun, timeout_err
  );
endinterface

// File: rtl/ghost_scheduler.sv
// Ghost scheduler: sequences one compute round over 4 ghosts per frame_tick and owns the map port.
// Latency: ghost_start 1 cycle after accepted tick; map_x/map_y follow idx by 1 cycle; 3 cycles per ghost + ghost time.
// Backpressure: waits on each ghost's is_ready handshake; ticks during a round are dropped and flagged as overrun.
// Optional watchdog on the WAIT states: define GHOST_TIMEOUT_EN.
module ghost_scheduler #(
  parameter int NUM_GHOSTS     = 4,
  parameter int TIMEOUT_CYCLES = 63
) (
  input logic              clock_50,
  input logic              reset,
  ghost_scheduler_if.master gif
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, WAIT_READY, SAMPLE, NEXT, DONE
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_GHOSTS - 1);

  // Only a 4-ghost round and a non-zero watchdog limit are meaningful.
  generate
    if (NUM_GHOSTS != 4 || TIMEOUT_CYCLES < 1) begin : g_unsupported_cfg
    end
  endgenerate

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [4:0] map_x_q, map_y_q;
  logic       caught_q, caught_d;
  logic [1:0] caught_id_q, caught_id_d;
  logic       overrun_q, overrun_d;
  logic       ready_cur, hit_cur;

  assign ready_cur = gif.ghost_is_ready[idx_q];
  assign hit_cur   = gif.ghost_hit[idx_q];

`ifdef GHOST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expired;

  assign expired = (cnt_q == CNT_LIMIT);
`endif

  // Next-state, round bookkeeping and sticky flag updates
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    caught_d    = caught_q;
    caught_id_d = caught_id_q;
    // Any tick outside IDLE is dropped, including the DONE->IDLE cycle.
    overrun_d   = overrun_q | (gif.frame_tick && (state_q != IDLE));
`ifdef GHOST_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (gif.frame_tick && !caught_q) begin
          state_d = START;
          idx_d   = 2'd0;
        end
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!ready_cur) begin
          state_d = WAIT_READY;
`ifdef GHOST_TIMEOUT_EN
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = NEXT;
`endif
        end
      end
      WAIT_READY: begin
        if (ready_cur) begin
          state_d = SAMPLE;
`ifdef GHOST_TIMEOUT_EN
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = NEXT;
`endif
        end
      end
      SAMPLE: begin
        // First ghost to report a hit wins; later hits leave caught_id alone.
        if (hit_cur && !caught_q) begin
          caught_d    = 1'b1;
          caught_id_d = idx_q;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = START;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef GHOST_TIMEOUT_EN
  // Watchdog counts cycles within one WAIT state and restarts on every state change
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == WAIT_BUSY) || (state_q == WAIT_READY))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gif.timeout_err = timeout_q;
`else
  assign gif.timeout_err = 1'b0;
`endif

  // State, index and sticky status registers
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      caught_q    <= 1'b0;
      caught_id_q <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      caught_q    <= caught_d;
      caught_id_q <= caught_id_d;
      overrun_q   <= overrun_d;
    end
  end

  // Map coordinate of the active ghost, registered every cycle
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      map_x_q <= 5'd0;
      map_y_q <= 5'd0;
    end else begin
      map_x_q <= gif.ghost_map_x[int'(idx_q) * 5 +: 5];
      map_y_q <= gif.ghost_map_y[int'(idx_q) * 5 +: 5];
    end
  end

  assign gif.ghost_start   = (state_q == START) ? (NUM_GHOSTS'(1) << idx_q) : '0;
  assign gif.map_x         = map_x_q;
  assign gif.map_y         = map_y_q;
  assign gif.map_readwrite = (state_q == WAIT_BUSY) || (state_q == WAIT_READY);
  assign gif.round_busy    = (state_q != IDLE);
  assign gif.round_done    = (state_q == DONE);
  assign gif.pacman_caught = caught_q;
  assign gif.caught_id     = caught_id_q;
  assign gif.overrun       = overrun_q;

endmodule

// File: tb/tb_ghost_scheduler.sv
// Directed bench for ghost_scheduler: ghost handshakes are driven from the test tasks.
// Latency: checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: ghost ready is dropped 1 cycle after start and raised 3 cycles later.
module tb_ghost_scheduler;

  logic clock_50;
  logic reset;
  ghost_scheduler_if gif();

  ghost_scheduler #(.NUM_GHOSTS(4), .TIMEOUT_CYCLES(63)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .gif      (gif)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  int checks;
  int fails;
  int start_cnt;
  int done_cnt;
  logic [3:0] prev_start;
  int exp_mx[4];
  int exp_my[4];

  // Passive monitor: start pulses must be one-hot and never back to back
  initial prev_start = 4'b0;
  always @(negedge clock_50) begin
    if (gif.ghost_start != 4'b0) begin
      start_cnt++;
      checks++;
      if (!$onehot(gif.ghost_start) || prev_start != 4'b0) begin
        fails++;
        $display("FAIL start_pulse_shape: got %b after %b, required one-hot after 0000", gif.ghost_start, prev_start);
      end
    end
    if (gif.round_done === 1'b1) done_cnt++;
    prev_start = gif.ghost_start;
  end

  task automatic set_map(input int x0, x1, x2, x3, y0, y1, y2, y3);
    exp_mx[0] = x0; exp_mx[1] = x1; exp_mx[2] = x2; exp_mx[3] = x3;
    exp_my[0] = y0; exp_my[1] = y1; exp_my[2] = y2; exp_my[3] = y3;
    gif.ghost_map_x = {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
    gif.ghost_map_y = {5'(y3), 5'(y2), 5'(y1), 5'(y0)};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gif.frame_tick = 1'b0;
    gif.ghost_is_ready = 4'hF;
    repeat (2) @(negedge clock_50);
    reset = 1'b0;
    @(negedge clock_50);
  endtask

  task automatic pulse_tick();
    gif.frame_tick = 1'b1;
    @(negedge clock_50);
    gif.frame_tick = 1'b0;
  endtask

  // Waits for the start of ghost i, then plays that ghost's busy/ready handshake
  task automatic run_ghost(input int i);
    int n;
    logic [3:0] exp_start;
    exp_start = 4'b0001 << i;
    n = 0;
    while (gif.ghost_start == 4'b0 && n < 120) begin
      @(negedge clock_50);
      n++;
    end
    checks++;
    if (gif.ghost_start !== exp_start) begin
      fails++;
      $display("FAIL start_ghost%0d: got %b, required %b", i, gif.ghost_start, exp_start);
      return;
    end
    checks++;
    if (gif.map_readwrite !== 1'b0) begin
      fails++;
      $display("FAIL rw_in_start%0d: got %b, required 0", i, gif.map_readwrite);
    end
    @(negedge clock_50);
    gif.ghost_is_ready[i] = 1'b0;
    checks++;
    if (gif.map_readwrite !== 1'b1 || gif.map_x !== 5'(exp_mx[i]) || gif.map_y !== 5'(exp_my[i])) begin
      fails++;
      $display("FAIL map_wait%0d: got rw=%b x=%0d y=%0d, required rw=1 x=%0d y=%0d",
               i, gif.map_readwrite, gif.map_x, gif.map_y, exp_mx[i], exp_my[i]);
    end
    repeat (3) @(negedge clock_50);
    gif.ghost_is_ready[i] = 1'b1;
    @(negedge clock_50);
    checks++;
    if (gif.map_readwrite !== 1'b0) begin
      fails++;
      $display("FAIL rw_in_sample%0d: got %b, required 0", i, gif.map_readwrite);
    end
  endtask

  // Waits for round_done, optionally firing a tick in the DONE cycle
  task automatic wait_done(input bit tick_on_done);
    int n;
    n = 0;
    while (gif.round_done !== 1'b1 && n < 20) begin
      @(negedge clock_50);
      n++;
    end
    checks++;
    if (gif.round_done !== 1'b1 || gif.round_busy !== 1'b1) begin
      fails++;
      $display("FAIL round_done_seen: got done=%b busy=%b, required 1 1", gif.round_done, gif.round_busy);
    end
    if (tick_on_done) gif.frame_tick = 1'b1;
    @(negedge clock_50);
    gif.frame_tick = 1'b0;
    checks++;
    if (gif.round_done !== 1'b0 || gif.round_busy !== 1'b0) begin
      fails++;
      $display("FAIL round_end: got done=%b busy=%b, required 0 0", gif.round_done, gif.round_busy);
    end
  endtask

  task automatic run_round(input bit tick_on_done);
    pulse_tick();
    for (int g = 0; g < 4; g++) run_ghost(g);
    wait_done(tick_on_done);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gif.frame_tick = 1'b0;
    gif.ghost_is_ready = 4'hF;
    gif.ghost_hit = 4'h0;
    set_map(2, 7, 15, 20, 4, 12, 25, 30);
    repeat (2) @(negedge clock_50);
    checks++;
    if (gif.ghost_start !== 4'b0 || gif.map_x !== 5'd0 || gif.map_y !== 5'd0 ||
        gif.map_readwrite !== 1'b0 || gif.round_busy !== 1'b0 || gif.round_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_datapath: got start=%b x=%0d y=%0d rw=%b busy=%b done=%b, required all 0",
               gif.ghost_start, gif.map_x, gif.map_y, gif.map_readwrite, gif.round_busy, gif.round_done);
    end
    checks++;
    if (gif.pacman_caught !== 1'b0 || gif.caught_id !== 2'd0 || gif.overrun !== 1'b0 || gif.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got caught=%b id=%0d ovr=%b to=%b, required all 0",
               gif.pacman_caught, gif.caught_id, gif.overrun, gif.timeout_err);
    end
    reset = 1'b0;
    @(negedge clock_50);
  endtask

  task automatic test_round();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt;
    run_round(1'b0);
    checks++;
    if (start_cnt - s0 != 4 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL round_counts: got starts=%0d dones=%0d, required 4 1", start_cnt - s0, done_cnt - d0);
    end
    checks++;
    if (gif.pacman_caught !== 1'b0 || gif.overrun !== 1'b0 || gif.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL round_flags: got caught=%b ovr=%b to=%b, required 0 0 0",
               gif.pacman_caught, gif.overrun, gif.timeout_err);
    end
  endtask

  task automatic test_map();
    set_map(31, 7, 0, 19, 1, 12, 16, 8);
    run_round(1'b0);
    set_map(10, 21, 5, 3, 29, 6, 17, 0);
    run_round(1'b0);
  endtask

  task automatic test_caught();
    int s0;
    do_reset();
    gif.ghost_hit = 4'b1100;
    run_round(1'b0);
    checks++;
    if (gif.pacman_caught !== 1'b1 || gif.caught_id !== 2'd2) begin
      fails++;
      $display("FAIL caught: got caught=%b id=%0d, required 1 2", gif.pacman_caught, gif.caught_id);
    end
    s0 = start_cnt;
    pulse_tick();
    repeat (15) @(negedge clock_50);
    checks++;
    if (start_cnt != s0 || gif.round_busy !== 1'b0 || gif.overrun !== 1'b0) begin
      fails++;
      $display("FAIL tick_after_caught: got starts=%0d busy=%b ovr=%b, required 0 0 0",
               start_cnt - s0, gif.round_busy, gif.overrun);
    end
    gif.ghost_hit = 4'b0000;
  endtask

  task automatic test_overrun();
    int s0, d0;
    do_reset();
    s0 = start_cnt; d0 = done_cnt;
    pulse_tick();
    run_ghost(0);
    pulse_tick();
    checks++;
    if (gif.overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b, required 1", gif.overrun);
    end
    for (int g = 1; g < 4; g++) run_ghost(g);
    wait_done(1'b0);
    repeat (10) @(negedge clock_50);
    checks++;
    if (start_cnt - s0 != 4 || done_cnt - d0 != 1 || gif.overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_round: got starts=%0d dones=%0d ovr=%b, required 4 1 1",
               start_cnt - s0, done_cnt - d0, gif.overrun);
    end
  endtask

  task automatic test_done_tick();
    int s0;
    do_reset();
    run_round(1'b1);
    s0 = start_cnt;
    repeat (10) @(negedge clock_50);
    checks++;
    if (gif.overrun !== 1'b1 || start_cnt != s0 || gif.round_busy !== 1'b0) begin
      fails++;
      $display("FAIL done_tick: got ovr=%b starts=%0d busy=%b, required 1 0 0",
               gif.overrun, start_cnt - s0, gif.round_busy);
    end
  endtask

  task automatic test_reset_mid();
    int s0, d0, n;
    do_reset();
    pulse_tick();
    run_ghost(0);
    n = 0;
    while (gif.ghost_start == 4'b0 && n < 20) begin
      @(negedge clock_50);
      n++;
    end
    @(negedge clock_50);
    gif.ghost_is_ready[1] = 1'b0;
    @(negedge clock_50);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clock_50);
    checks++;
    if (gif.ghost_start !== 4'b0 || gif.map_x !== 5'd0 || gif.map_y !== 5'd0 || gif.map_readwrite !== 1'b0 ||
        gif.round_busy !== 1'b0 || gif.round_done !== 1'b0 || gif.overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got start=%b x=%0d y=%0d rw=%b busy=%b done=%b ovr=%b, required all 0",
               gif.ghost_start, gif.map_x, gif.map_y, gif.map_readwrite, gif.round_busy, gif.round_done, gif.overrun);
    end
    reset = 1'b0;
    gif.ghost_is_ready = 4'hF;
    s0 = start_cnt;
    repeat (12) @(negedge clock_50);
    checks++;
    if (done_cnt != d0 || start_cnt != s0) begin
      fails++;
      $display("FAIL reset_mid_quiet: got dones=%0d starts=%0d, required 0 0", done_cnt - d0, start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int s0;
    do_reset();
    s0 = start_cnt;
    pulse_tick();
    repeat (30) @(negedge clock_50);
    checks++;
    if (gif.timeout_err !== 1'b0 || gif.map_readwrite !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: got to=%b rw=%b, required 0 1", gif.timeout_err, gif.map_readwrite);
    end
`ifdef GHOST_TIMEOUT_EN
    run_ghost(1);
    checks++;
    if (gif.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_set: got %b, required 1", gif.timeout_err);
    end
    run_ghost(2);
    run_ghost(3);
    wait_done(1'b0);
`else
    repeat (100) @(negedge clock_50);
    checks++;
    if (gif.timeout_err !== 1'b0 || gif.round_busy !== 1'b1 || start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL no_watchdog: got to=%b busy=%b starts=%0d, required 0 1 1",
               gif.timeout_err, gif.round_busy, start_cnt - s0);
    end
    do_reset();
`endif
  endtask

  initial begin
    checks = 0;
    fails = 0;
    start_cnt = 0;
    done_cnt = 0;
    test_reset();
    test_round();
    test_map();
    test_caught();
    test_overrun();
    test_done_tick();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
